// File: rtl/mem_disp_reader.sv
// mem_disp_reader: periodically reads a display word from the top of data
// memory over the read-only port b and scans it onto an 8-digit hex display.
// Ports: clk, rst (async active-low), sel (word offset below 0x7FF),
//   blank (all digits off), addrb/doutb (port-b read, 1-cycle latency),
//   word/word_valid (captured word, update pulse), an/seg (active-low).
module mem_disp_reader #(
  parameter int SAMPLE_DIV = 16,
  parameter int SCAN_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        blank,
  output logic [10:0] addrb,
  input  logic [31:0] doutb,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    CAP
  } state_e;

  state_e                state_q;
  logic                  pending_q;
  logic [10:0]           addrb_q;
  logic [31:0]           word_q;
  logic                  wv_q;
  logic [SAMPLE_DIV-1:0] smp_q;
  logic [SCAN_DIV-1:0]   scan_q;
  logic [2:0]            sel_q;
  logic [7:0]            an_q;
  logic [7:0]            seg_q;
  logic [7:0]            an_d;
  logic [7:0]            seg_d;

  logic       smp_tick;
  logic       sel_chg;
  logic       set_evt;
  logic       take;
  logic [2:0] digit;
  logic [3:0] nib;
  logic [6:0] hex;

  assign smp_tick = &smp_q;
  assign sel_chg  = (sel != sel_q);
  assign set_evt  = smp_tick | sel_chg;
  assign take     = (state_q == IDLE) & pending_q;

  // Read FSM. The issuing edge samples the live sel, so any event that
  // coincides with it is already served and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
      addrb_q   <= 11'h7FF;
      word_q    <= 32'd0;
      wv_q      <= 1'b0;
    end else begin
      wv_q      <= 1'b0;
      pending_q <= take ? 1'b0 : (pending_q | set_evt);
      unique case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q <= ADDR;
            addrb_q <= 11'h7FF - {8'd0, sel};
          end
        end
        ADDR: state_q <= WAIT;
        WAIT: begin
          state_q <= CAP;
          word_q  <= doutb;
          wv_q    <= 1'b1;
        end
        CAP:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit = scan_q[SCAN_DIV-1 -: 3];
  assign nib   = word_q[{digit, 2'b00} +: 4];

  always_comb begin
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end

  // dp on the leftmost digit marks a non-default word offset
  always_comb begin
    an_d  = blank ? 8'hFF : ~(8'd1 << digit);
    seg_d = {~((digit == 3'd7) && (sel != 3'd0)), hex};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q  <= '0;
      scan_q <= '0;
      sel_q  <= 3'd0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      smp_q  <= smp_q + SAMPLE_DIV'(1);
      scan_q <= scan_q + SCAN_DIV'(1);
      sel_q  <= sel;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign addrb      = addrb_q;
  assign word       = word_q;
  assign word_valid = wv_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_mem_disp_reader.sv
// tb_mem_disp_reader: scoreboard bench for mem_disp_reader with a 1-cycle
// synchronous RAM model, directed timing checks and randomized sel/data.
module tb_mem_disp_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        blank = 1'b0;
  logic [10:0] addrb;
  logic [31:0] doutb = 32'd0;
  logic [31:0] word;
  logic        word_valid;
  logic [7:0]  an;
  logic [7:0]  seg;

  mem_disp_reader #(
    .SAMPLE_DIV(6),
    .SCAN_DIV  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .blank     (blank),
    .addrb     (addrb),
    .doutb     (doutb),
    .word      (word),
    .word_valid(word_valid),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  always @(posedge clk) doutb <= mem[addrb];

  int cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ok = 32'd0;
  logic [6:0]  hex7 [16];

  // Monitor: every update pulse is checked against the scoreboard. A
  // repeat of the last accepted word is a periodic re-read and is legal.
  always @(negedge clk) begin
    if (rst && word_valid) begin
      pulses++;
      n_cmp++;
      if (exp_q.size() != 0) begin
        if (word === exp_q[0]) begin
          last_ok = exp_q.pop_front();
        end else if (word !== last_ok) begin
          n_bad++;
          $display("FAIL word_pulse: got %08h, required %08h", word, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end else if (word !== last_ok) begin
        n_bad++;
        $display("FAIL word_reread: got %08h, required %08h", word, last_ok);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", nm, act, req);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d reads outstanding after %0d cycles, required 0",
               nm, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Reference scan: registered view of the counter value before the edge.
  task automatic scan_check(input string nm, input int n,
                            input logic [31:0] w);
    int k;
    int d;
    logic [7:0] ea;
    logic [7:0] es;
    for (int i = 0; i < n; i++) begin
      step(1);
      k  = (cyc - 1) % 16;
      d  = k / 2;
      ea = blank ? 8'hFF : ~(8'd1 << d);
      es = {~((d == 7) && (sel != 3'd0)), hex7[w[4*d +: 4]]};
      chk({nm, "_an"}, {24'd0, an}, {24'd0, ea});
      chk({nm, "_seg"}, {24'd0, seg}, {24'd0, es});
    end
  endtask

  task automatic go_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_ok = 32'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [2:0]  cur;
    logic [2:0]  s;
    logic [31:0] dat;

    hex7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[11'h7FF] = 32'h12345678;
    mem[11'h7FE] = 32'hDEADBEEF;

    step(3);
    chk("rst_addrb", {21'd0, addrb}, 32'h7FF);
    chk("rst_word", word, 32'd0);
    chk("rst_wv", {31'd0, word_valid}, 32'd0);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);

    rst = 1'b1;
    exp_q.push_back(32'h12345678);
    step(1);
    chk("first_addrb", {21'd0, addrb}, 32'h7FF);
    chk("first_wv1", {31'd0, word_valid}, 32'd0);
    step(1);
    chk("first_wv2", {31'd0, word_valid}, 32'd0);
    step(1);
    chk("first_wv3", {31'd0, word_valid}, 32'd1);
    chk("first_word", word, 32'h12345678);
    drain("first_drain", 2);

    step(5);
    scan_check("scan", 16, 32'h12345678);

    sel = 3'd1;
    exp_q.push_back(32'hDEADBEEF);
    step(2);
    chk("selchg_addrb", {21'd0, addrb}, 32'h7FE);
    step(2);
    chk("selchg_wv", {31'd0, word_valid}, 32'd1);
    chk("selchg_word", word, 32'hDEADBEEF);
    drain("selchg_drain", 2);
    scan_check("scan_dp", 16, 32'hDEADBEEF);

    sel = 3'd0;
    exp_q.push_back(32'h12345678);
    drain("back0", 20);
    mem[11'h7FF] = 32'h0000000F;
    exp_q.push_back(32'h0000000F);
    drain("periodic", 68);
    chk("periodic_word", word, 32'h0000000F);
    scan_check("scan_f", 16, 32'h0000000F);

    go_reset();
    mem[11'h7FF] = 32'h12345678;
    step(2);
    rst = 1'b1;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    p0 = pulses;
    step(2);
    sel = 3'd1;
    step(20);
    chk("waitsel_pulses", pulses - p0, 32'd2);
    chk("waitsel_addrb", {21'd0, addrb}, 32'h7FE);
    drain("waitsel_drain", 4);

    blank = 1'b1;
    step(1);
    chk("blank_an1", {24'd0, an}, 32'hFF);
    step(3);
    chk("blank_an4", {24'd0, an}, 32'hFF);
    blank = 1'b0;
    scan_check("unblank", 16, 32'hDEADBEEF);

    sel = 3'd0;
    step(2);
    rst = 1'b0;
    #1;
    chk("abort_word", word, 32'd0);
    chk("abort_wv", {31'd0, word_valid}, 32'd0);
    chk("abort_addrb", {21'd0, addrb}, 32'h7FF);
    exp_q.delete();
    last_ok = 32'd0;
    sel = 3'd1;
    step(2);
    rst = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    p0 = pulses;
    step(15);
    chk("restart_pulses", pulses - p0, 32'd1);
    drain("restart_drain", 4);
    chk("restart_addrb", {21'd0, addrb}, 32'h7FE);

    cur = 3'd1;
    for (int it = 0; it < 12; it++) begin
      s = cur;
      while (s == cur) s = 3'($urandom_range(0, 7));
      dat = $urandom;
      mem[11'h7FF - {8'd0, s}] = dat;
      step($urandom_range(0, 6));
      sel = s;
      exp_q.push_back(dat);
      drain("rand_drain", 24);
      chk("rand_addrb", {21'd0, addrb}, 32'h7FF - {29'd0, s});
      cur = s;
    end

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
